// File: rtl/cdb_arbiter_rr.sv
// Common data bus arbiter: grants up to CDB_WIDTH of NUM_FU results per cycle, parking losers in per-FU hold registers.
// Define CDB_ARB_RR_EN for round-robin scanning; without it the scan is fixed priority from FU0.
module cdb_arbiter_rr #(
    parameter int NUM_FU    = 8,
    parameter int CDB_WIDTH = 2,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int SRC_W     = $clog2(NUM_FU)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]     fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]    fu_data,
    output logic [NUM_FU-1:0]           fu_ready,
    output logic [CDB_WIDTH-1:0]        cdb_valid,
    output logic [CDB_WIDTH*TAG_W-1:0]  cdb_tag,
    output logic [CDB_WIDTH*DATA_W-1:0] cdb_data,
    output logic [CDB_WIDTH*SRC_W-1:0]  cdb_src
);

    logic [NUM_FU-1:0] hold_valid;
    logic [TAG_W-1:0]  hold_tag  [NUM_FU];
    logic [DATA_W-1:0] hold_data [NUM_FU];

    logic [NUM_FU-1:0] accept;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] grant;
    logic [TAG_W-1:0]  req_tag  [NUM_FU];
    logic [DATA_W-1:0] req_data [NUM_FU];

    logic [SRC_W-1:0]  scan_base;
    logic [SRC_W-1:0]  scan_idx;
    logic [SRC_W:0]    scan_sum;
    int                grant_cnt;

    logic [CDB_WIDTH-1:0] slot_valid;
    logic [TAG_W-1:0]     slot_tag  [CDB_WIDTH];
    logic [DATA_W-1:0]    slot_data [CDB_WIDTH];
    logic [SRC_W-1:0]     slot_src  [CDB_WIDTH];

    assign fu_ready = ~hold_valid;
    assign accept   = fu_valid & ~hold_valid;

    // A held entry always takes precedence over the (ignored) input of that FU.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            req[i]      = hold_valid[i] | accept[i];
            req_tag[i]  = hold_valid[i] ? hold_tag[i]  : fu_tag[i*TAG_W +: TAG_W];
            req_data[i] = hold_valid[i] ? hold_data[i] : fu_data[i*DATA_W +: DATA_W];
        end
    end

`ifdef CDB_ARB_RR_EN
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] last_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (!squash && (|grant)) begin
            rr_ptr <= (last_idx == SRC_W'(NUM_FU - 1)) ? '0 : last_idx + SRC_W'(1);
        end
    end

    assign scan_base = rr_ptr;
`else
    assign scan_base = '0;
`endif

    always_comb begin
        grant      = '0;
        grant_cnt  = 0;
        scan_sum   = '0;
        scan_idx   = '0;
        slot_valid = '0;
`ifdef CDB_ARB_RR_EN
        last_idx   = '0;
`endif
        for (int k = 0; k < CDB_WIDTH; k++) begin
            slot_tag[k]  = '0;
            slot_data[k] = '0;
            slot_src[k]  = '0;
        end
        for (int j = 0; j < NUM_FU; j++) begin
            scan_sum = {1'b0, scan_base} + (SRC_W+1)'(j);
            if (scan_sum >= (SRC_W+1)'(NUM_FU)) begin
                scan_sum = scan_sum - (SRC_W+1)'(NUM_FU);
            end
            scan_idx = scan_sum[SRC_W-1:0];
            if (req[scan_idx] && (grant_cnt < CDB_WIDTH)) begin
                grant[scan_idx] = 1'b1;
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (grant_cnt == k) begin
                        slot_valid[k] = 1'b1;
                        slot_tag[k]   = req_tag[scan_idx];
                        slot_data[k]  = req_data[scan_idx];
                        slot_src[k]   = scan_idx;
                    end
                end
`ifdef CDB_ARB_RR_EN
                last_idx = scan_idx;
`endif
                grant_cnt = grant_cnt + 1;
            end
        end
    end

    // Hold registers: a granted entry leaves, an accepted loser is parked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                hold_tag[i]  <= '0;
                hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (squash || grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end else if (accept[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
                    hold_data[i]  <= fu_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Broadcast registers; empty slots carry all-zero fields.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (squash) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else begin
            cdb_valid <= slot_valid;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_tag[k*TAG_W +: TAG_W]    <= slot_tag[k];
                cdb_data[k*DATA_W +: DATA_W] <= slot_data[k];
                cdb_src[k*SRC_W +: SRC_W]    <= slot_src[k];
            end
        end
    end

endmodule
